// File: rtl/mseq_modulator.sv
// mseq_modulator
//
// Baseband source and modulator stage. Each rising edge of the bit-rate clock
// clk_m produces one framed data bit. A frame is an alternating preamble
// (1,0,1,0,...) of PREAMBLE_LEN bits followed by one full period (2^W-1 bits)
// of a maximal-length LFSR sequence. Frames repeat back to back while enable
// stays high. The framed bit stream keys the carrier clk_carry to form mod_out.
//
// Configuration macro:
//   MSEQ_BPSK_EN  defined   : mod_out = seq_bit ? clk_carry : ~clk_carry (BPSK)
//                 undefined : mod_out = clk_carry & seq_bit             (OOK)
//   In both modes mod_out is held at 0 while the FSM is IDLE.
//
// Ports:
//   clk          in   system clock (50 MHz)
//   rst_n        in   asynchronous active-low reset
//   clk_m        in   bit-rate clock, synchronous to clk
//   clk_carry    in   carrier clock
//   enable       in   transmit request, sampled only at bit events
//   seq_bit      out  current framed data bit (registered)
//   bit_strobe   out  one-cycle pulse when seq_bit updates
//   frame_start  out  one-cycle pulse with the first preamble bit of a frame
//   mod_out      out  modulated carrier (registered)
//   state        out  FSM state: 0 IDLE, 1 PREAMBLE, 2 SEQUENCE

module mseq_modulator #(
  parameter int                    LFSR_WIDTH   = 7,
  parameter logic [LFSR_WIDTH-1:0] TAPS         = 7'b1100000,
  parameter logic [LFSR_WIDTH-1:0] SEED         = 7'b0000001,
  parameter int                    PREAMBLE_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_m,
  input  logic       clk_carry,
  input  logic       enable,
  output logic       seq_bit,
  output logic       bit_strobe,
  output logic       frame_start,
  output logic       mod_out,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_SEQUENCE = 2'd2
  } state_t;

  localparam logic [7:0]            PRE_LEN  = 8'(PREAMBLE_LEN);
  localparam logic [LFSR_WIDTH-1:0] SEQ_LAST = '1;
  localparam logic [LFSR_WIDTH-1:0] SEQ_ONE  = {{(LFSR_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic                  r_clk_m_d;
  logic                  r_seq_bit;
  logic                  r_bit_strobe;
  logic                  r_frame_start;
  logic                  r_mod_out;
  logic [7:0]            r_pre_cnt;
  logic [LFSR_WIDTH-1:0] r_seq_cnt;
  logic [LFSR_WIDTH-1:0] r_lfsr;

  state_t                w_next_state;
  logic                  w_bit_event;
  logic                  w_pre_done;
  logic                  w_seq_done;
  logic [LFSR_WIDTH-1:0] w_lfsr_shift;
  logic                  w_next_seq_bit;
  logic                  w_next_frame_start;
  logic                  w_next_mod;
  logic                  w_mod_raw;
  logic [7:0]            w_next_pre_cnt;
  logic [LFSR_WIDTH-1:0] w_next_seq_cnt;
  logic [LFSR_WIDTH-1:0] w_next_lfsr;

  // clk_m_d resets to 1 so a clk_m already high at reset release is not
  // mistaken for a rising edge.
  assign w_bit_event  = clk_m & ~r_clk_m_d;
  assign w_pre_done   = (r_pre_cnt == PRE_LEN);
  assign w_seq_done   = (r_seq_cnt == SEQ_LAST);
  assign w_lfsr_shift = {r_lfsr[LFSR_WIDTH-2:0], ^(r_lfsr & TAPS)};

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_clk_m_d     <= 1'b1;
      r_seq_bit     <= 1'b0;
      r_bit_strobe  <= 1'b0;
      r_frame_start <= 1'b0;
      r_mod_out     <= 1'b0;
      r_pre_cnt     <= 8'd0;
      r_seq_cnt     <= '0;
      r_lfsr        <= SEED;
    end else begin
      r_state       <= w_next_state;
      r_clk_m_d     <= clk_m;
      r_seq_bit     <= w_next_seq_bit;
      r_bit_strobe  <= w_bit_event;
      r_frame_start <= w_next_frame_start;
      r_mod_out     <= w_next_mod;
      r_pre_cnt     <= w_next_pre_cnt;
      r_seq_cnt     <= w_next_seq_cnt;
      r_lfsr        <= w_next_lfsr;
    end
  end

  // Next-state logic. A low enable at an event always wins, including on the
  // last body bit, so a dropped request never starts a new frame.
  always_comb begin
    w_next_state = r_state;
    if (w_bit_event) begin
      if (!enable) begin
        w_next_state = ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE:     w_next_state = ST_PREAMBLE;
          ST_PREAMBLE: if (w_pre_done) w_next_state = ST_SEQUENCE;
          ST_SEQUENCE: if (w_seq_done) w_next_state = ST_PREAMBLE;
          default:     w_next_state = ST_IDLE;
        endcase
      end
    end
  end

  // Output and datapath next values. Every frame start reloads SEED so that
  // all frames are bit-identical.
  always_comb begin
    w_next_seq_bit     = r_seq_bit;
    w_next_frame_start = 1'b0;
    w_next_pre_cnt     = r_pre_cnt;
    w_next_seq_cnt     = r_seq_cnt;
    w_next_lfsr        = r_lfsr;
    if (w_bit_event) begin
      if (!enable || (r_state != ST_IDLE && r_state != ST_PREAMBLE &&
                      r_state != ST_SEQUENCE)) begin
        w_next_seq_bit = 1'b0;
        w_next_pre_cnt = 8'd0;
        w_next_seq_cnt = '0;
        w_next_lfsr    = SEED;
      end else if (r_state == ST_IDLE ||
                   (r_state == ST_SEQUENCE && w_seq_done)) begin
        w_next_seq_bit     = 1'b1;
        w_next_frame_start = 1'b1;
        w_next_pre_cnt     = 8'd1;
        w_next_seq_cnt     = '0;
        w_next_lfsr        = SEED;
      end else if (r_state == ST_PREAMBLE && !w_pre_done) begin
        // Preamble bit n (1-based) is 1 for odd n; the next bit is n+1.
        w_next_seq_bit = ~r_pre_cnt[0];
        w_next_pre_cnt = r_pre_cnt + 8'd1;
      end else begin
        // Body bit: either the first one after the preamble or a later one.
        w_next_seq_bit = r_lfsr[LFSR_WIDTH-1];
        w_next_lfsr    = w_lfsr_shift;
        w_next_pre_cnt = 8'd0;
        w_next_seq_cnt = (r_state == ST_PREAMBLE) ? SEQ_ONE : r_seq_cnt + SEQ_ONE;
      end
    end

    // The carrier is keyed by the bit that seq_bit will show next cycle, so
    // mod_out changes together with seq_bit and state.
`ifdef MSEQ_BPSK_EN
    w_mod_raw = w_next_seq_bit ? clk_carry : ~clk_carry;
`else
    w_mod_raw = clk_carry & w_next_seq_bit;
`endif
    w_next_mod = (w_next_state == ST_IDLE) ? 1'b0 : w_mod_raw;
  end

  assign seq_bit     = r_seq_bit;
  assign bit_strobe  = r_bit_strobe;
  assign frame_start = r_frame_start;
  assign mod_out     = r_mod_out;
  assign state       = r_state;

endmodule

// File: tb/tb_mseq_modulator.sv
// tb_mseq_modulator
//
// Scoreboard bench for mseq_modulator (default parameters). Each bit-clock
// pulse pushes the expected {seq_bit, frame_start, state} onto a queue; a
// monitor pops and compares on every bit_strobe, and checks mod_out every
// cycle against the delayed carrier and the expected bit/state.

module tb_mseq_modulator;

  typedef struct packed {
    logic       seqBit;
    logic       frameStart;
    logic [1:0] state;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_m = 1'b0;
  logic       clk_carry = 1'b0;
  logic       enable = 1'b0;
  logic       seq_bit;
  logic       bit_strobe;
  logic       frame_start;
  logic       mod_out;
  logic [1:0] state;

  int   checkCount = 0;
  int   failCount = 0;
  exp_t expQ[$];
  logic obsBits[$];
  logic capture = 1'b0;
  logic body[127];
  int   mPhase = 0;
  int   mIdx = 0;
  logic expSeqBit = 1'b0;
  logic [1:0] expState = 2'd0;
  logic carryD = 1'b0;
  int   carryDiv = 0;
  exp_t monE;
  logic expMod;

  mseq_modulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_m       (clk_m),
    .clk_carry   (clk_carry),
    .enable      (enable),
    .seq_bit     (seq_bit),
    .bit_strobe  (bit_strobe),
    .frame_start (frame_start),
    .mod_out     (mod_out),
    .state       (state)
  );

  // 100 MHz-style bench clock; absolute rate does not matter to the design.
  always #5 clk = ~clk;

  // Carrier toggles every three clocks so it changes within a bit period.
  always @(negedge clk) begin
    carryDiv = carryDiv + 1;
    if (carryDiv == 3) begin
      carryDiv = 0;
      clk_carry = ~clk_carry;
    end
  end

  // Carrier value the DUT sampled at the last rising edge.
  always @(posedge clk) carryD = clk_carry;

  // Single comparison point: counts every check and reports failures.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount = checkCount + 1;
    if (actual !== expected) begin
      failCount = failCount + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reference frame model: advances one bit event and returns what the DUT
  // should show afterwards.
  function automatic exp_t modelStep(input logic en);
    exp_t e;
    if (!en) begin
      mPhase = 0;
      mIdx = 0;
      e = '{seqBit: 1'b0, frameStart: 1'b0, state: 2'd0};
    end else if (mPhase == 0 || (mPhase == 2 && mIdx == 127)) begin
      mPhase = 1;
      mIdx = 1;
      e = '{seqBit: 1'b1, frameStart: 1'b1, state: 2'd1};
    end else if (mPhase == 1 && mIdx == 8) begin
      mPhase = 2;
      mIdx = 1;
      e = '{seqBit: body[0], frameStart: 1'b0, state: 2'd2};
    end else if (mPhase == 1) begin
      mIdx = mIdx + 1;
      e = '{seqBit: logic'(mIdx % 2), frameStart: 1'b0, state: 2'd1};
    end else begin
      e = '{seqBit: body[mIdx], frameStart: 1'b0, state: 2'd2};
      mIdx = mIdx + 1;
    end
    return e;
  endfunction

  // One bit period: set enable, queue the expected result, pulse clk_m
  // (2 clocks high, 2 low). Called on a falling clk edge.
  task automatic applyStimulus(input logic en);
    exp_t e;
    enable = en;
    e = modelStep(en);
    expQ.push_back(e);
    clk_m = 1'b1;
    repeat (2) @(negedge clk);
    clk_m = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_seq_bit"}, seq_bit, 0);
    checkOutput({tag, "_bit_strobe"}, bit_strobe, 0);
    checkOutput({tag, "_frame_start"}, frame_start, 0);
    checkOutput({tag, "_mod_out"}, mod_out, 0);
    checkOutput({tag, "_state"}, state, 0);
  endtask

  // Monitor: pops on each strobe, flags strobes nobody asked for, and checks
  // mod_out every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      expSeqBit = 1'b0;
      expState = 2'd0;
    end else if (expQ.size() == 0) begin
      checkOutput("spuriousStrobe", bit_strobe, 0);
    end else if (bit_strobe) begin
      monE = expQ.pop_front();
      checkOutput("seq_bit", seq_bit, monE.seqBit);
      checkOutput("frame_start", frame_start, monE.frameStart);
      checkOutput("state", state, monE.state);
      expSeqBit = monE.seqBit;
      expState = monE.state;
      if (capture) obsBits.push_back(seq_bit);
    end
`ifdef MSEQ_BPSK_EN
    expMod = (expState == 2'd0) ? 1'b0 : (expSeqBit ? carryD : ~carryD);
`else
    expMod = (expState == 2'd0) ? 1'b0 : (expSeqBit & carryD);
`endif
    checkOutput("mod_out", mod_out, expMod);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ones;
    int diff;
    logic [14:0] got15;
    logic [14:0] want15;

    // m-sequence reference from its recurrence s[n] = s[n-7] ^ s[n-6].
    for (int i = 0; i < 7; i++) body[i] = (i == 6);
    for (int n = 7; n < 127; n++) body[n] = body[n-7] ^ body[n-6];

    // Reset held while clk_m toggles; release with clk_m high.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) clk_m = 1'b1;
      @(negedge clk) clk_m = 1'b0;
    end
    @(negedge clk) clk_m = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checkAllZero("resetRelease");
    repeat (3) @(negedge clk);
    clk_m = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] idle with enable low");
    applyStimulus(1'b0);
    applyStimulus(1'b0);

    // Two full frames back to back.
    $display("[TB] frame start and repeat");
    capture = 1'b1;
    for (int i = 0; i < 270; i++) applyStimulus(1'b1);
    capture = 1'b0;
    checkOutput("capturedBits", obsBits.size(), 270);
    if (obsBits.size() == 270) begin
      want15 = 15'b101010100000001;
      for (int i = 0; i < 15; i++) got15[14-i] = obsBits[i];
      checkOutput("first15Bits", got15, want15);
      ones = 0;
      for (int i = 8; i < 135; i++) ones = ones + int'(obsBits[i]);
      checkOutput("bodyOnes", ones, 64);
      diff = 0;
      for (int i = 0; i < 135; i++) if (obsBits[i] !== obsBits[i+135]) diff++;
      checkOutput("frameRepeatDiffs", diff, 0);
    end

    // Drop enable in the body, then re-enable.
    $display("[TB] mid-sequence drop");
    for (int i = 0; i < 48; i++) applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b1);

    // Asynchronous reset between strobes in the preamble.
    $display("[TB] async reset mid-preamble");
    checkOutput("preResetSeqBit", seq_bit, 1);
    #2 rst_n = 1'b0;
    #1 checkAllZero("asyncReset");
    expQ.delete();
    mPhase = 0;
    mIdx = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1);

    // Finish this frame, then drop enable exactly at the frame boundary.
    $display("[TB] frame end with enable low");
    for (int i = 0; i < 126; i++) applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b0);

    repeat (4) @(negedge clk);
    checkOutput("pendingStrobes", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mseq_modulator.md
# mseq_modulator

Baseband source and modulator stage placed directly downstream of the clock generator. It consumes the bit-rate clock (`clk_m`, 4 kHz from 50 MHz) and the carrier clock (`clk_CarryWave`, 2 MHz). It emits framed data: an alternating preamble followed by one full maximal-length (m-)sequence period, repeated while enabled. The framed bit stream gates or phase-keys the carrier to produce the transmit waveform.

## Interface
Parameters:
- `LFSR_WIDTH`, default 7: LFSR length W; the frame body is 2^W-1 bits.
- `TAPS`, default 7'b1100000: feedback mask (x^7+x^6+1).
- `SEED`, default 7'b0000001: LFSR load value; must be non-zero.
- `PREAMBLE_LEN`, default 8: number of preamble bits, range 1..255.

Ports:
- `clk` in 1: system clock (50 MHz). One clock; reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous, active-low reset.
- `clk_m` in 1: bit-rate clock from the clock generator, synchronous to `clk`.
- `clk_carry` in 1: carrier from the clock generator (`clk_CarryWave`).
- `enable` in 1: transmit request.
- `seq_bit` out 1: current framed data bit.
- `bit_strobe` out 1: one-cycle pulse when `seq_bit` updates.
- `frame_start` out 1: one-cycle pulse coincident with the first preamble bit of each frame.
- `mod_out` out 1: modulated carrier.
- `state` out 2: FSM state. 0 = IDLE, 1 = PREAMBLE, 2 = SEQUENCE.

## Operation
- Edge detect: register `clk_m` into `clk_m_d`. A bit event occurs in any cycle where `clk_m`=1 and `clk_m_d`=0.
  - `clk_m_d` resets to 1, so a `clk_m` that is already high at reset release produces no event.
- On each bit event, all registers below update on that clock edge, and `bit_strobe`=1 for exactly that following cycle.
- FSM, evaluated only at bit events:
  - IDLE with `enable`=1 → PREAMBLE. `seq_bit`←1, preamble count←1, `frame_start`=1.
  - IDLE with `enable`=0 → stay in IDLE. `seq_bit` stays 0.
  - PREAMBLE with `enable`=1:
    - Emits alternating bits 1,0,1,0,…
    - After `PREAMBLE_LEN` bits have been emitted, the next event → SEQUENCE.
  - SEQUENCE with `enable`=1:
    - On each event: `seq_bit`←lfsr[W-1], then lfsr←{lfsr[W-2:0], ^(lfsr & TAPS)}.
    - After 2^W-1 bits, the next event → PREAMBLE. This is a new frame: `frame_start`=1, lfsr←SEED.
  - PREAMBLE or SEQUENCE with `enable`=0 at an event → IDLE. `seq_bit`←0, lfsr←SEED, all counters←0.
- `enable` changes between events are ignored.
- A frame restart always reloads SEED, so every frame is bit-identical regardless of the `TAPS` choice.
- Default body start (SEED 0000001): 0,0,0,0,0,0,1,…
- Counter widths: preamble counter 8 bits; sequence counter W bits. No wrap occurs inside a frame.

## Timing
- Reset (async assert, sync release) values:
  - `seq_bit`=0, `bit_strobe`=0, `frame_start`=0, `mod_out`=0, `state`=0.
  - lfsr=SEED, counters=0, `clk_m_d`=1.
- Latency:
  - `seq_bit`, `bit_strobe`, `frame_start` and `state` are registered, 1 clk after the edge at which the rising `clk_m` is sampled.
  - `mod_out` is registered, 1 clk after its `clk_carry`/`seq_bit` inputs.
- `clk_m` high and low phases must each be at least 1 clk. The bench may drive a faster `clk_m` than 4 kHz.
- Reset mid-frame: outputs drop to reset values immediately. The frame restarts from PREAMBLE on the first event after `enable` is seen high.
- Simultaneous frame end and `enable`=0: IDLE takes priority. `frame_start` stays 0.

## Configuration
- `MSEQ_BPSK_EN` defined: `mod_out` = `clk_carry` when `seq_bit`=1, and ~`clk_carry` when `seq_bit`=0 (BPSK).
- `MSEQ_BPSK_EN` undefined: `mod_out` = `clk_carry` & `seq_bit` (OOK).
- In both cases `mod_out` is forced to 0 in IDLE.

## Test plan
- Reset and idle:
  - Stimulus: hold `rst_n`=0 with `clk_m` toggling; release reset with `clk_m`=1.
  - Required: all outputs 0; no `bit_strobe` until the next real rising edge of `clk_m`.
- Frame start:
  - Stimulus: `enable`=1.
  - Required at successive strobes: `seq_bit` = 1,0,1,0,1,0,1,0, then 0,0,0,0,0,0,1; `frame_start` only on the first strobe; `state` 1 then 2.
- Frame repeat:
  - Stimulus: keep `enable`=1 for 270 strobes.
  - Required: `frame_start` on strobes 1 and 136; the 127-bit body contains 64 ones; frame 2 is bit-identical to frame 1.
- Mid-sequence drop:
  - Stimulus: drop `enable` at body bit 40.
  - Required: at the next strobe `state`=0, `seq_bit`=0, `mod_out`=0. Re-enabling restarts with preamble bit 1.
- Async reset:
  - Stimulus: assert `rst_n`=0 in mid-preamble, between strobes.
  - Required: outputs zero in the same cycle; after release and `enable`, the full preamble is replayed.
- Modulation mode:
  - With `MSEQ_BPSK_EN` defined: `mod_out` equals `clk_carry` delayed 1 clk while `seq_bit`=1, and inverted while `seq_bit`=0.
  - Without it: `mod_out`=0 whenever `seq_bit`=0.
